// File: rtl/hedios_tx_arbiter.sv
// hedios_tx_arbiter: round-robin arbiter (optional strict priority for
// requester 0) feeding one Hedios serial TX packet queue.
// Ports: clk/rst (sync, active-high); req_valid/req_command/req_data in,
//   req_ready out (one-hot accept pulse); push_packet/packet_command/
//   packet_data out to the TX queue, queue_full in; grant_idx (last winner),
//   stall_count (saturating count of back-pressured arbitration cycles).
// Latency: valid sampled in ARB cycle T -> push_packet/req_ready high in T+1.
// Throughput: at most one packet every 2 cycles (ARB, HOLD).
module hedios_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter bit PRIO0 = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_command,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 push_packet,
  output logic [7:0]           packet_command,
  output logic [31:0]          packet_data,
  input  logic                 queue_full,
  output logic [2:0]           grant_idx,
  output logic [15:0]          stall_count
);

  typedef enum logic {ARB, HOLD} state_t;

  state_t     state;
  logic [2:0] last_grant;

  logic       any_valid;
  logic       prio_hit;
  logic       found;
  logic [2:0] win;
  int         idx;

  // Winner selection. The round-robin search starts one past last_grant and
  // wraps, so only indices below N_REQ are ever candidates.
  always_comb begin
    any_valid = |req_valid;
    prio_hit  = PRIO0 && req_valid[0];
    found     = 1'b0;
    win       = '0;
    idx       = 0;
    if (prio_hit) begin
      win   = '0;
      found = 1'b1;
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        idx = (int'(last_grant) + k) % N_REQ;
        if (!found && req_valid[idx]) begin
          win   = 3'(idx);
          found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ARB;
      last_grant     <= 3'(N_REQ - 1);
      grant_idx      <= '0;
      req_ready      <= '0;
      push_packet    <= 1'b0;
      packet_command <= '0;
      packet_data    <= '0;
      stall_count    <= '0;
    end else begin
      case (state)
        ARB: begin
          if (any_valid && queue_full) begin
            if (stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
          end else if (any_valid && found) begin
            packet_command <= req_command[int'(win)*8 +: 8];
            packet_data    <= req_data[int'(win)*32 +: 32];
            push_packet    <= 1'b1;
            req_ready      <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
            grant_idx      <= win;
            // Priority grants leave the rotation pointer where it was.
            if (!prio_hit) last_grant <= win;
            state          <= HOLD;
          end
        end
        HOLD: begin
          // Gives the queue's full flag a cycle to reflect this push and
          // keeps the granted requester from being sampled in its ready cycle.
          push_packet <= 1'b0;
          req_ready   <= '0;
          state       <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_hedios_tx_arbiter.sv
// tb_hedios_tx_arbiter: directed vectors for hedios_tx_arbiter, one
// round-robin instance (PRIO0=0) and one strict-priority instance (PRIO0=1).
module tb_hedios_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;

  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_command = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           push_packet;
  logic [7:0]     packet_command;
  logic [31:0]    packet_data;
  logic           queue_full = 1'b0;
  logic [2:0]     grant_idx;
  logic [15:0]    stall_count;

  logic [N-1:0]   p_valid = '0;
  logic [8*N-1:0] p_command = '0;
  logic [32*N-1:0] p_data = '0;
  logic [N-1:0]   p_ready;
  logic           p_push;
  logic [7:0]     p_pcmd;
  logic [31:0]    p_pdata;
  logic           p_full = 1'b0;
  logic [2:0]     p_gidx;
  logic [15:0]    p_stall;

  int n_vec = 0;
  int n_err = 0;
  int push_cnt = 0;
  int snap;

  always #5 clk = ~clk;

  always @(posedge clk) if (push_packet) push_cnt <= push_cnt + 1;

  hedios_tx_arbiter #(.N_REQ(N), .PRIO0(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_command(req_command), .req_data(req_data),
    .req_ready(req_ready), .push_packet(push_packet),
    .packet_command(packet_command), .packet_data(packet_data),
    .queue_full(queue_full), .grant_idx(grant_idx), .stall_count(stall_count)
  );

  hedios_tx_arbiter #(.N_REQ(N), .PRIO0(1'b1)) dut_prio (
    .clk(clk), .rst(rst),
    .req_valid(p_valid), .req_command(p_command), .req_data(p_data),
    .req_ready(p_ready), .push_packet(p_push),
    .packet_command(p_pcmd), .packet_data(p_pdata),
    .queue_full(p_full), .grant_idx(p_gidx), .stall_count(p_stall)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] cmd_of(input int i);
    return 8'(8'h10 + i);
  endfunction

  function automatic logic [31:0] dat_of(input int i);
    return 32'hA5000000 + 32'(i * 32'h111);
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      req_command[i*8 +: 8] = cmd_of(i);
      req_data[i*32 +: 32]  = dat_of(i);
      p_command[i*8 +: 8]   = cmd_of(i);
      p_data[i*32 +: 32]    = dat_of(i);
    end

    // Reset state
    do_reset();
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_push", 64'(push_packet), 64'h0);
    check("rst_cmd", 64'(packet_command), 64'h0);
    check("rst_data", 64'(packet_data), 64'h0);
    check("rst_gidx", 64'(grant_idx), 64'h0);
    check("rst_stall", 64'(stall_count), 64'h0);

    // Single request from requester 2
    req_command[2*8 +: 8]  = 8'h21;
    req_data[2*32 +: 32]   = 32'hDEADBEEF;
    snap = push_cnt;
    req_valid = 4'b0100;
    tick();
    check("single_push", 64'(push_packet), 64'h1);
    check("single_ready", 64'(req_ready), 64'h4);
    check("single_gidx", 64'(grant_idx), 64'h2);
    check("single_cmd", 64'(packet_command), 64'h21);
    check("single_data", 64'(packet_data), 64'hDEADBEEF);
    req_valid = '0;
    tick();
    check("single_hold_push", 64'(push_packet), 64'h0);
    check("single_hold_ready", 64'(req_ready), 64'h0);
    check("single_cmd_kept", 64'(packet_command), 64'h21);
    repeat (4) tick();
    check("single_one_push", 64'(push_cnt - snap), 64'h1);
    req_command[2*8 +: 8] = cmd_of(2);
    req_data[2*32 +: 32]  = dat_of(2);

    // All requesters valid: strict rotation, one push every 2 cycles
    do_reset();
    req_valid = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      tick();
      check($sformatf("rr_push%0d", g), 64'(push_packet), 64'h1);
      check($sformatf("rr_gidx%0d", g), 64'(grant_idx), 64'(g % 4));
      check($sformatf("rr_ready%0d", g), 64'(req_ready), 64'(1 << (g % 4)));
      check($sformatf("rr_cmd%0d", g), 64'(packet_command), 64'(cmd_of(g % 4)));
      check($sformatf("rr_data%0d", g), 64'(packet_data), 64'(dat_of(g % 4)));
      tick();
      check($sformatf("rr_gap%0d", g), 64'(push_packet), 64'h0);
    end
    req_valid = '0;
    tick();

    // Back-pressure: 10 stalled cycles, then release
    do_reset();
    snap = push_cnt;
    queue_full = 1'b1;
    req_valid = 4'b0011;
    repeat (10) tick();
    check("bp_no_push", 64'(push_cnt - snap), 64'h0);
    check("bp_stall10", 64'(stall_count), 64'd10);
    queue_full = 1'b0;
    tick();
    check("bp_rel_push", 64'(push_packet), 64'h1);
    check("bp_rel_gidx", 64'(grant_idx), 64'h0);
    check("bp_rel_stall", 64'(stall_count), 64'd10);
    req_valid = '0;
    tick();

    // Saturation of stall_count
    do_reset();
    queue_full = 1'b1;
    req_valid = 4'b0001;
    repeat (65534) tick();
    check("sat_fffe", 64'(stall_count), 64'hFFFE);
    tick();
    check("sat_ffff", 64'(stall_count), 64'hFFFF);
    repeat (5) tick();
    check("sat_hold", 64'(stall_count), 64'hFFFF);
    check("sat_no_push", 64'(push_packet), 64'h0);
    queue_full = 1'b0;
    req_valid = '0;

    // Strict priority instance: requester 0 wins until it drops
    do_reset();
    p_valid = 4'b0011;
    for (int g = 0; g < 3; g++) begin
      tick();
      check($sformatf("prio_push%0d", g), 64'(p_push), 64'h1);
      check($sformatf("prio_gidx%0d", g), 64'(p_gidx), 64'h0);
      if (g == 2) p_valid = 4'b0010;
      tick();
    end
    tick();
    check("prio_r1_push", 64'(p_push), 64'h1);
    check("prio_r1_gidx", 64'(p_gidx), 64'h1);
    check("prio_r1_ready", 64'(p_ready), 64'h2);
    check("prio_r1_data", 64'(p_pdata), 64'(dat_of(1)));
    p_valid = '0;

    // Reset during a grant decision
    do_reset();
    req_valid = 4'b0100;
    tick();
    check("mid_pre_gidx", 64'(grant_idx), 64'h2);
    req_valid = '0;
    tick();
    req_valid = 4'b1111;
    rst = 1'b1;
    tick();
    check("mid_rst_push", 64'(push_packet), 64'h0);
    check("mid_rst_ready", 64'(req_ready), 64'h0);
    rst = 1'b0;
    tick();
    check("mid_after_push", 64'(push_packet), 64'h1);
    check("mid_after_gidx", 64'(grant_idx), 64'h0);
    check("mid_after_ready", 64'(req_ready), 64'h1);
    req_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
